// File: rtl/mb_crc3_pkg.sv
// Shared definitions for the CRC-3 byte link: FSM encoding, frame geometry
// and the single-bit CRC step used by generator, checker and receiver.
package mb_crc3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2,
    ST_STOP = 2'd3
  } rx_state_t;

  localparam int              CRC_W        = 3;
  localparam int              DATA_W       = 8;
  localparam int              FRAME_BITS   = 13;
  localparam logic [CRC_W-1:0] POLY_DEFAULT = 3'b011;

  // One serial LFSR step; the x^3 term is implicit in the shift-out of crc[2].
  function automatic logic [CRC_W-1:0] crc3_step(input logic [CRC_W-1:0] crc,
                                                 input logic             b,
                                                 input logic [CRC_W-1:0] poly);
    logic fb;
    fb = crc[CRC_W-1] ^ b;
    return {crc[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb}} & poly);
  endfunction

endpackage

// File: rtl/mb_crc3_lfsr.sv
// Serial CRC-3 LFSR with synchronous clear and shift enable; clear wins.
import mb_crc3_pkg::*;

module mb_crc3_lfsr #(
  parameter logic [CRC_W-1:0] POLY = POLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc3_step(crc, din, POLY);
    end
  end

endmodule

// File: rtl/mb_crc3_rx.sv
// CRC-3 link receiver: frames start/8 data/3 CRC/stop, deserializes the byte
// and reports CRC and framing errors plus a saturating bad-frame count.
import mb_crc3_pkg::*;

module mb_crc3_rx #(
  parameter int               DATA_BITS = DATA_W,
  parameter logic [CRC_W-1:0] POLY      = POLY_DEFAULT
) (
  input  logic                 GCLK,
  input  logic                 Clear_bar,
  input  logic                 Serial_In,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Valid,
  output logic                 ErrorOut,
  output logic                 Frame_Err,
  output logic [7:0]           Err_Cnt,
  output logic [1:0]           dbg_state
);

  // Valid is a one-cycle strobe with no ready: the link cannot be stalled,
  // so the consumer must take Data_Out/flags in the cycle Valid is high.

  rx_state_t              state;
  logic [2:0]             bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic [CRC_W-1:0]       crc;
  logic                   lfsr_clr;
  logic                   lfsr_en;

  assign lfsr_clr  = (state == ST_IDLE) && !Serial_In;
  assign lfsr_en   = (state == ST_DATA) || (state == ST_CRC);
  assign dbg_state = state;

  mb_crc3_lfsr #(.POLY(POLY)) u_lfsr (
    .clk   (GCLK),
    .rst_n (Clear_bar),
    .clr   (lfsr_clr),
    .en    (lfsr_en),
    .din   (Serial_In),
    .crc   (crc)
  );

  always_ff @(posedge GCLK or negedge Clear_bar) begin
    if (!Clear_bar) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      Data_Out  <= '0;
      Valid     <= 1'b0;
      ErrorOut  <= 1'b0;
      Frame_Err <= 1'b0;
      Err_Cnt   <= '0;
    end else begin
      Valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!Serial_In) begin
            bit_cnt <= '0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          shreg <= {shreg[DATA_BITS-2:0], Serial_In};
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            bit_cnt <= '0;
            state   <= ST_CRC;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        ST_CRC: begin
          if (bit_cnt == 3'(CRC_W - 1)) begin
            bit_cnt <= '0;
            state   <= ST_STOP;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        ST_STOP: begin
          Data_Out  <= shreg;
          ErrorOut  <= |crc;
          Frame_Err <= ~Serial_In;
          Valid     <= 1'b1;
          if (((|crc) || !Serial_In) && (Err_Cnt != 8'hFF)) begin
            Err_Cnt <= Err_Cnt + 8'd1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mb_crc3_rx.sv
// Randomized bench for mb_crc3_rx: frames are generated from a polynomial
// division model, expected results queued, and a monitor checks each Valid.
import mb_crc3_pkg::*;

module tb_mb_crc3_rx;

  logic       GCLK = 1'b0;
  logic       Clear_bar;
  logic       Serial_In;
  logic [7:0] Data_Out;
  logic       Valid;
  logic       ErrorOut;
  logic       Frame_Err;
  logic [7:0] Err_Cnt;
  logic [1:0] dbg_state;

  mb_crc3_rx dut (
    .GCLK      (GCLK),
    .Clear_bar (Clear_bar),
    .Serial_In (Serial_In),
    .Data_Out  (Data_Out),
    .Valid     (Valid),
    .ErrorOut  (ErrorOut),
    .Frame_Err (Frame_Err),
    .Err_Cnt   (Err_Cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 GCLK = ~GCLK;

  int unsigned cyc = 0;
  always @(posedge GCLK) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0]  d;
    logic        ce;
    logic        fe;
    logic [7:0]  cnt;
    logic [31:0] at;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  exp_t mon_e;
  int   model_cnt;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
  endtask

  // Remainder of d(x)*x^3 mod x^3+x+1 by long division.
  function automatic logic [2:0] crc_ref(input logic [7:0] d);
    logic [10:0] r;
    r = {d, 3'b000};
    for (int i = 10; i >= 3; i--) begin
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    end
    return r[2:0];
  endfunction

  // driver tasks: inputs change 2 time units after the rising edge
  task automatic drive_bit(input logic b);
    @(posedge GCLK);
    #2;
    Serial_In = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [2:0] c,
                            input logic stop, input int gap);
    exp_t e;
    logic ce;
    drive_bit(1'b0);
    ce = (c != crc_ref(d));
    if ((ce || !stop) && model_cnt < 255) model_cnt++;
    e.d   = d;
    e.ce  = ce;
    e.fe  = !stop;
    e.cnt = 8'(model_cnt);
    e.at  = cyc + 13;
    exp_q.push_back(e);
    for (int i = 7; i >= 0; i--) drive_bit(d[i]);
    for (int i = 2; i >= 0; i--) drive_bit(c[i]);
    drive_bit(stop);
    idle(gap);
  endtask

  task automatic check_reset_outputs();
    @(negedge GCLK);
    check("rst_data", 32'(Data_Out), 32'h00);
    check("rst_valid", 32'(Valid), 32'h0);
    check("rst_crc_err", 32'(ErrorOut), 32'h0);
    check("rst_frame_err", 32'(Frame_Err), 32'h0);
    check("rst_err_cnt", 32'(Err_Cnt), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // scoreboard monitor
  always @(negedge GCLK) begin
    if (Clear_bar === 1'b1) begin
      if (Valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'h1, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check("data", 32'(Data_Out), 32'(mon_e.d));
          check("crc_err", 32'(ErrorOut), 32'(mon_e.ce));
          check("frame_err", 32'(Frame_Err), 32'(mon_e.fe));
          check("err_cnt", 32'(Err_Cnt), 32'(mon_e.cnt));
          check("valid_cycle", cyc, mon_e.at);
          check("state_idle", 32'(dbg_state), 32'(ST_IDLE));
          last_exp = mon_e;
        end
      end else begin
        check("hold_data", 32'(Data_Out), 32'(last_exp.d));
        check("hold_crc_err", 32'(ErrorOut), 32'(last_exp.ce));
        check("hold_frame_err", 32'(Frame_Err), 32'(last_exp.fe));
        check("hold_err_cnt", 32'(Err_Cnt), 32'(last_exp.cnt));
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic [2:0] c;
    logic       stop;
    Clear_bar = 1'b0;
    Serial_In = 1'b1;
    last_exp  = '0;
    model_cnt = 0;
    repeat (2) @(negedge GCLK);
    check_reset_outputs();
    @(posedge GCLK);
    #2;
    Clear_bar = 1'b1;
    idle(3);

    // directed frames
    send_frame(8'hA5, 3'b101, 1'b1, 2);
    send_frame(8'h01, 3'b011, 1'b1, 0);
    send_frame(8'h80, 3'b011, 1'b1, 3);
    send_frame(8'hAD, 3'b101, 1'b1, 2);
    send_frame(8'h00, 3'b000, 1'b0, 3);
    idle(3);

    // reset after the 5th data bit of an A5 frame
    drive_bit(1'b0);
    d = 8'hA5;
    for (int i = 7; i >= 3; i--) drive_bit(d[i]);
    @(posedge GCLK);
    #2;
    Clear_bar = 1'b0;
    Serial_In = 1'b1;
    last_exp  = '0;
    model_cnt = 0;
    check_reset_outputs();
    @(posedge GCLK);
    #2;
    Clear_bar = 1'b1;
    idle(2);
    send_frame(8'hA5, 3'b101, 1'b1, 3);

    // random frames with occasional CRC and stop-bit corruption
    for (int n = 0; n < 150; n++) begin
      d    = 8'($urandom_range(0, 255));
      c    = crc_ref(d);
      if ($urandom_range(0, 3) == 0) c = c ^ 3'($urandom_range(1, 7));
      stop = ($urandom_range(0, 6) != 0);
      send_frame(d, c, stop, $urandom_range(0, 3));
    end
    idle(2);

    // saturation of the bad-frame counter
    for (int n = 0; n < 260; n++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(d, crc_ref(d) ^ 3'b001, 1'b1, 0);
    end
    idle(1);

    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge GCLK);
    check("drain", 32'(exp_q.size()), 32'h0);
    @(negedge GCLK);
    check("err_cnt_sat", 32'(Err_Cnt), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mb_crc3_rx.md
# mb_crc3_rx

Serial-link receiver for the CRC-3 protected byte link: it samples the single-bit line once per GCLK, frames each transfer, deserializes the 8 data bits and checks the 3 trailing CRC bits. It outputs the byte with a one-cycle valid strobe, a CRC error flag and a framing error flag. It also keeps a saturating count of bad frames. It sits at the far end of the link, downstream of the CRC-3 generator and the error-injection point.

## Interface
- `DATA_BITS`, 8: data bits per frame. Fixed at 8 for this revision.
- `POLY`, 3'b011: low-order taps of the CRC polynomial x^3+x+1. The x^3 term is implicit.
- `GCLK` input 1: single clock. Every register is rising-edge.
- `Clear_bar` input 1: reset, asynchronous, active-low.
- `Serial_In` input 1: link line, sampled every GCLK. Idles high.
- `Data_Out` output 8: last received byte, MSB = first data bit received.
- `Valid` output 1: one-cycle strobe marking a completed frame.
- `ErrorOut` output 1: CRC remainder of the last frame was nonzero.
- `Frame_Err` output 1: stop bit of the last frame was sampled 0.
- `Err_Cnt` output 8: count of frames with ErrorOut or Frame_Err set. Saturates at 255.

## Operation
- Frame format, 13 bits, one bit per GCLK:
  - start bit = 0
  - D7..D0, MSB first
  - C2..C0, MSB first
  - stop bit = 1
- CRC definition:
  - The CRC is the remainder of M(x)·x^3 mod x^3+x+1, with initial value 000.
  - Serial LFSR update per bit b: `fb = crc[2]^b`, then `crc <= {crc[1], crc[0]^fb, fb}`.
  - The LFSR is cleared to 000 on the start bit.
  - It absorbs the 8 data bits and the 3 CRC bits. A remainder of 000 after those 11 bits means the frame is good.
- FSM states:
  - IDLE: if `Serial_In`=0, clear the LFSR and bit counter, then go to DATA. Otherwise stay in IDLE.
  - DATA: shift the bit into the data shift register and the LFSR. After 8 bits, go to CRC.
  - CRC: shift the bit into the LFSR only. After 3 bits, go to STOP.
  - STOP: sample the stop bit and update all outputs, then go to IDLE.
- Bit counter: 3 bits wide, reused by DATA (0..7) and CRC (0..2).
- Frame completion, on the STOP edge:
  - `Data_Out` takes the shift register value.
  - `ErrorOut` = (LFSR ≠ 000).
  - `Frame_Err` = ~`Serial_In`.
  - `Valid` = 1 for exactly one cycle.
  - `Err_Cnt` increments by 1 if either flag is set, and holds at 255.
- Hold behaviour: `Data_Out`, `ErrorOut` and `Frame_Err` hold until the next frame completes. No output changes mid-frame.
- Errored frames: the byte is still presented. The flags qualify it.
- Framing error: the FSM returns to IDLE with no resync search. The next 0 seen in IDLE is taken as a start bit.
- Back-to-back frames: a start bit in the cycle right after STOP is accepted. The line needs no idle gap.

## Timing
- Reset values: `Data_Out`=8'h00, `Valid`=0, `ErrorOut`=0, `Frame_Err`=0, `Err_Cnt`=0. Internal state: FSM=IDLE, LFSR=000.
- Reset mid-frame: the partial frame is discarded and no `Valid` is produced. Reception resumes from IDLE after `Clear_bar` is released.
- Latency: if the start bit is sampled at edge N, the stop bit is sampled and `Valid` rises at edge N+12. `Valid` is high for the cycle that follows that edge.
- Maximum throughput: one frame per 13 GCLK cycles.
- All outputs are registered. There is no combinational path from `Serial_In` to any output.

## Structure
- Shared package `mb_crc3_pkg` holds:
  - the FSM state encoding (IDLE, DATA, CRC, STOP)
  - `CRC_W`=3, `FRAME_BITS`=13, the default `POLY`
  - the function `crc3_step(crc, bit)`, shared with the generator and checker blocks
- One natural sub-module: `mb_crc3_lfsr`, the serial LFSR with clear, enable and remainder output. It is reused by the generator side.

## Test plan
- Frame 0xA5 with CRC 101 and stop=1 → `Data_Out`=8'hA5, `ErrorOut`=0, `Frame_Err`=0, `Valid` pulses at edge N+12, `Err_Cnt`=0.
- Frames 0x01 and 0x80, each with CRC 011, sent back-to-back with no idle gap → two `Valid` pulses exactly 13 cycles apart, data 01 then 80, no errors.
- Frame 0xA5 with D3 inverted (received 0xAD), CRC 101 → `Data_Out`=8'hAD, `ErrorOut`=1, `Err_Cnt`=1.
- Frame 0x00, CRC 000, stop=0 → `Frame_Err`=1, `ErrorOut`=0, `Err_Cnt` increments, FSM back in IDLE.
- `Clear_bar` asserted after the 5th data bit, then a full 0xA5 frame → only one `Valid`, with data A5. All outputs read reset values during reset.
- 260 consecutive bad-CRC frames → `Err_Cnt` reaches 255 and holds. `Valid` pulses 260 times.
